binary_search_guesser: RTL and testbench

Sequential initiator that finds an unknown WIDTH-bit value held on the X side of a magnitude comparator. It drives trial values onto the comparator's Y input and reads back lt/gt/eq. It runs a binary search over [0, 2^WIDTH-1] and reports the value found, the number of probes used, and any protocol error. It sits on the far side of the lab's 4-bit comparator and closes the loop that the comparator responds to.

---
 rtl/binary_search_guesser_if.sv | 28 ++
 rtl/binary_search_guesser.sv | 120 ++++++++++++
 tb/tb_binary_search_guesser.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/binary_search_guesser_if.sv
// Connection bundle between the binary-search guesser and the side that holds
// the secret value: request, comparator flags, and the search outcome.
interface binary_search_guesser_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             fail;
  logic [WIDTH-1:0] result;
  logic [3:0]       steps;

  // Requester / comparator side.
  modport master (
    output start, lt, gt, eq,
    input  guess, busy, done, fail, result, steps
  );

  // Guesser side.
  modport slave (
    input  start, lt, gt, eq,
    output guess, busy, done, fail, result, steps
  );
endinterface

// File: rtl/binary_search_guesser.sv
// Binary-search initiator: drives trial values to a magnitude comparator and
// narrows [lo, hi] from the lt/gt/eq answers until it hits or detects an error.
module binary_search_guesser #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  binary_search_guesser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MID_INIT = ALL_ONES >> 1;
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       steps_q, steps_d;
  logic [WIDTH:0]   sum_down, sum_up;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    steps_d  = steps_q;

    // Midpoints are formed one bit wider so lo+hi can never wrap.
    sum_down = {1'b0, lo_q} + {1'b0, guess_q} - ONE_X;
    sum_up   = {1'b0, guess_q} + ONE_X + {1'b0, hi_q};

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (bus.start) begin
          lo_d    = '0;
          hi_d    = ALL_ONES;
          guess_d = MID_INIT;
          steps_d = '0;
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: state_d = S_SAMPLE;

      S_SAMPLE: begin
        steps_d = (steps_q == 4'hF) ? steps_q : steps_q + 4'd1;
        unique case ({bus.lt, bus.gt, bus.eq})
          3'b001: begin
            result_d = guess_q;
            state_d  = S_DONE;
          end
          3'b100: begin
            // The secret is below guess; nothing is left if guess is already lo.
            if (guess_q == lo_q) begin
              state_d = S_FAIL;
            end else begin
              hi_d    = guess_q - ONE_W;
              guess_d = sum_down[WIDTH:1];
              state_d = S_DRIVE;
            end
          end
          3'b010: begin
            if (guess_q == hi_q) begin
              state_d = S_FAIL;
            end else begin
              lo_d    = guess_q + ONE_W;
              guess_d = sum_up[WIDTH:1];
              state_d = S_DRIVE;
            end
          end
          default: state_d = S_FAIL;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;
  assign bus.busy   = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.fail   = (state_q == S_FAIL);

endmodule

// File: tb/tb_binary_search_guesser.sv
// Self-checking bench: a comparator model answers the guesser, and each search
// is compared against a reference search computed directly from the rules.
module tb_binary_search_guesser;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic rst;

  binary_search_guesser_if #(.WIDTH(W)) bus ();

  binary_search_guesser #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: 0 = honest comparator, 1 = always "too high", 2 = lt and gt both.
  int secret;
  int mode;

  always_comb begin
    bus.lt = 1'b0;
    bus.gt = 1'b0;
    bus.eq = 1'b0;
    case (mode)
      0: begin
        bus.lt = (secret < int'(bus.guess));
        bus.gt = (secret > int'(bus.guess));
        bus.eq = (secret == int'(bus.guess));
      end
      1: bus.lt = 1'b1;
      default: begin
        bus.lt = 1'b1;
        bus.gt = 1'b1;
      end
    endcase
  end

  int n_cmp;
  int n_bad;

  int got_seq[$];
  int got_edges;
  int exp_seq[$];
  bit exp_fail;

  // Reference: plain interval halving over [0, MAXV] using the responder's rules.
  task automatic model_search(input int x, input int md);
    int lo, hi, g;
    lo = 0;
    hi = MAXV;
    exp_seq.delete();
    exp_fail = 1'b0;
    forever begin
      g = (lo + hi) / 2;
      exp_seq.push_back(g);
      if (md == 2) begin
        exp_fail = 1'b1;
        break;
      end
      if (md == 0 && g == x) break;
      if (md == 1 || x < g) begin
        if (g == lo) begin exp_fail = 1'b1; break; end
        hi = g - 1;
      end else begin
        if (g == hi) begin exp_fail = 1'b1; break; end
        lo = g + 1;
      end
    end
  endtask

  function automatic string seq_str(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  // Launch a search from a post-edge sample point; optionally re-pulse start
  // right after edge number 'glitch' so it lands on a later edge.
  task automatic run_search(input int x, input int md, input int glitch);
    secret = x;
    mode   = md;
    got_seq.delete();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    got_edges = 1;
    while (!(bus.done || bus.fail)) begin
      if (got_edges % 2 == 1) begin
        got_seq.push_back(int'(bus.guess));
      end else begin
        n_cmp++;
        if (int'(bus.guess) !== got_seq[$]) begin
          n_bad++;
          $display("FAIL guess_stable: edge %0d guess=%0d, expected %0d", got_edges, bus.guess, got_seq[$]);
        end
      end
      if (got_edges == glitch) bus.start = 1'b1;
      if (got_edges >= 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL search_timeout: x=%0d no done/fail after %0d edges", x, got_edges);
        break;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      got_edges++;
    end
  endtask

  task automatic check_search(input string name, input int x, input int md);
    int exp_steps;
    model_search(x, md);
    exp_steps = (exp_seq.size() > 15) ? 15 : exp_seq.size();

    n_cmp++;
    if (got_seq != exp_seq) begin
      n_bad++;
      $display("FAIL %s_sequence: x=%0d got [ %s] expected [ %s]", name, x, seq_str(got_seq), seq_str(exp_seq));
    end
    n_cmp++;
    if (bus.fail !== exp_fail || bus.done !== !exp_fail) begin
      n_bad++;
      $display("FAIL %s_outcome: x=%0d done=%0b fail=%0b, expected fail=%0b", name, x, bus.done, bus.fail, exp_fail);
    end
    n_cmp++;
    if (got_edges !== 1 + 2 * exp_seq.size()) begin
      n_bad++;
      $display("FAIL %s_latency: x=%0d edges=%0d, expected %0d", name, x, got_edges, 1 + 2 * exp_seq.size());
    end
    n_cmp++;
    if (int'(bus.steps) !== exp_steps) begin
      n_bad++;
      $display("FAIL %s_steps: x=%0d steps=%0d, expected %0d", name, x, bus.steps, exp_steps);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy: x=%0d busy=%0b after completion, expected 0", name, x, bus.busy);
    end
    if (!exp_fail) begin
      n_cmp++;
      if (int'(bus.result) !== x) begin
        n_bad++;
        $display("FAIL %s_result: result=%0d, expected %0d", name, bus.result, x);
      end
      n_cmp++;
      if (int'(bus.steps) > W + 1) begin
        n_bad++;
        $display("FAIL %s_probe_bound: x=%0d steps=%0d, expected <= %0d", name, x, bus.steps, W + 1);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (bus.guess !== '0 || bus.result !== '0 || bus.steps !== 4'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fail !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: guess=%0d result=%0d steps=%0d busy=%0b done=%0b fail=%0b, expected all 0",
               name, bus.guess, bus.result, bus.steps, bus.busy, bus.done, bus.fail);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    secret = 0;
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_held");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("idle_without_start");
  endtask

  task automatic test_directed;
    run_search(7, 0, -1);
    check_search("x7", 7, 0);
    run_search(0, 0, -1);
    check_search("x0", 0, 0);
    run_search(15, 0, -1);
    check_search("x15", 15, 0);
  endtask

  task automatic test_sweep;
    int order[$];
    for (int i = 0; i <= MAXV; i++) order.push_back(i);
    // Random visiting order so each search starts from a different prior state.
    for (int i = MAXV; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    foreach (order[k]) begin
      run_search(order[k], 0, -1);
      check_search("sweep", order[k], 0);
    end
    for (int r = 0; r < 8; r++) begin
      int x;
      x = $urandom_range(MAXV, 0);
      run_search(x, 0, -1);
      check_search("random", x, 0);
    end
  endtask

  task automatic test_bad_responder;
    run_search(0, 1, -1);
    check_search("always_lt", 0, 1);
    run_search(9, 2, -1);
    check_search("lt_and_gt", 9, 2);
    mode = 0;
  endtask

  task automatic test_start_while_busy;
    run_search(15, 0, 2);
    check_search("start_in_sample", 15, 0);
    run_search(15, 0, 4);
    check_search("start_in_sample2", 15, 0);
  endtask

  task automatic test_restart_from_done;
    int budget;
    run_search(15, 0, -1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.steps !== 4'd0 || int'(bus.guess) !== 7 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: steps=%0d guess=%0d done=%0b busy=%0b, expected 0/7/0/1",
               bus.steps, bus.guess, bus.done, bus.busy);
    end
    budget = 0;
    while (!bus.done && budget < 40) begin
      @(posedge clk); #1;
      budget++;
    end
    n_cmp++;
    if (bus.done !== 1'b1 || int'(bus.result) !== 15) begin
      n_bad++;
      $display("FAIL restart_result: done=%0b result=%0d, expected 1/15", bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid_search;
    secret = 12;
    mode = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("no_auto_restart");
    run_search(12, 0, -1);
    check_search("after_reset", 12, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_sweep();
    test_bad_responder();
    test_start_while_busy();
    test_restart_from_done();
    test_reset_mid_search();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
